ami_mem_arbiter: RTL and testbench
==================================

AMI_MEM_ARBITER -- requirements
Module: ami_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64: request address width.
REQ-002 Parameter DATA_W, default 512: request/response data width.
REQ-003 Parameter SIZE_W, default 64: request/response size field width, in bytes.
REQ-004 Parameter MAX_OUT, default 4: maximum outstanding reads, range 1..15.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req0_valid/isWrite/addr/data/size  in  1/1/ADDR_W/DATA_W/SIZE_W  read-port request from the accelerator; req0_grant  out  1  one-cycle accept pulse.
REQ-008 req1_valid/isWrite/addr/data/size  in  same widths  write-port request; req1_grant  out  1  one-cycle accept pulse.
REQ-009 mem_req_valid/isWrite/addr/data/size  out  same widths  merged memory request; mem_req_grant  in  1  memory accepts the request this cycle.
REQ-010 mem_resp_valid/data/size  in  1/DATA_W/SIZE_W  memory read response; mem_resp_grant  out  1  arbiter accepts the response.
REQ-011 resp0_valid/data/size  out  1/DATA_W/SIZE_W  registered read response to the accelerator; resp0_grant  in  1  accelerator consumes it.
REQ-012 outstanding  out  4  reads currently in flight.
REQ-013 r_count, w_count  out  32 each  reads and writes issued to memory.
REQ-014 err_mismatch, err_unexpected  out  1 each  sticky error flags.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and HOLD.
REQ-016 In IDLE, the FSM SHALL choose one eligible requester. Eligibility:
- req1: req1_valid.
- req0: req0_valid and outstanding < MAX_OUT.
REQ-017 When both requesters are eligible, the arbiter SHALL grant round-robin: the port not granted last. The last-granted pointer resets to port 1, so port 0 wins the first tie.
REQ-018 On selection, the arbiter SHALL:
- pulse the chosen reqN_grant for exactly one cycle;
- register that request into the mem_req_* outputs;
- enter HOLD on the next cycle.
REQ-019 In HOLD, mem_req_valid SHALL be 1 and all mem_req_* fields SHALL stay stable. No reqN_grant is issued in HOLD.
REQ-020 In HOLD, when mem_req_grant=1:
- mem_req_valid SHALL drop next cycle and the FSM SHALL return to IDLE;
- for a read, r_count and outstanding SHALL increment;
- for a write, w_count SHALL increment.
The one-cycle bubble gives a peak issue rate of one request per 2 cycles.
REQ-021 A port-type mismatch (req0 with isWrite=1, or req1 with isWrite=0) SHALL be handled as follows:
- the request is granted but dropped;
- err_mismatch is set;
- the FSM stays in IDLE and the grant pointer is updated.
REQ-022 mem_resp_grant SHALL equal (!resp0_valid || resp0_grant).
REQ-023 An accepted memory response SHALL load resp0_data/size and set resp0_valid on the next cycle. resp0_valid clears when resp0_grant=1 and no new response loads in the same cycle.
REQ-024 outstanding SHALL decrement on each accepted mem_resp_valid. A simultaneous increment and decrement SHALL leave it unchanged.
REQ-025 A response accepted while outstanding=0 SHALL be dropped and SHALL set err_unexpected; outstanding stays 0 (no underflow).
REQ-026 r_count and w_count SHALL wrap modulo 2^32.
REQ-027 Error flags SHALL clear only on reset.

Reset
REQ-028 Asserting rst_n=0, at any time including mid-HOLD, SHALL immediately force:
- FSM to IDLE, grant pointer to port 1;
- all valid and grant outputs to 0;
- outstanding, r_count, w_count and both error flags to 0;
- data/addr/size outputs to 0.
REQ-029 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge on which a request is eligible.

Verification
REQ-030 Single read: req0 read at addr 0x40, size 64; mem_req_grant held 1 -> req0_grant pulses at cycle 1, mem_req_valid at cycle 2 with addr 0x40, r_count=1, outstanding=1.
REQ-031 Tie: req0 and req1 both held valid for 4 grants -> grant order 0,1,0,1; w_count=2; r_count=2.
REQ-032 Outstanding cap, MAX_OUT=4, no responses returned: 4 reads issued, then req0_grant stays 0 while outstanding=4. One response -> outstanding=3 and the next read is granted.
REQ-033 Response backpressure: two responses with resp0_grant=0 -> first held in resp0_data, mem_resp_grant=0; second is accepted only after resp0_grant=1.
REQ-034 Errors: req1 with isWrite=0 -> req1_grant pulses, mem_req_valid stays 0, err_mismatch=1. Response with outstanding=0 -> err_unexpected=1, outstanding stays 0.
REQ-035 Reset mid-HOLD with mem_req_grant=0 -> mem_req_valid=0 asynchronously, outstanding=0, and the next tie grants port 0.

Source files
------------

// File: rtl/ami_mem_arbiter.sv
// ami_mem_arbiter: round-robin merge of a read port and a write port onto one memory
// request channel, plus the registered read-response return path and issue bookkeeping.
`default_nettype none
module ami_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int SIZE_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_isWrite,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [SIZE_W-1:0] req0_size,
  output logic              req0_grant,
  input  logic              req1_valid,
  input  logic              req1_isWrite,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [SIZE_W-1:0] req1_size,
  output logic              req1_grant,
  output logic              mem_req_valid,
  output logic              mem_req_isWrite,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [SIZE_W-1:0] mem_req_size,
  input  logic              mem_req_grant,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic [SIZE_W-1:0] mem_resp_size,
  output logic              mem_resp_grant,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  output logic [SIZE_W-1:0] resp0_size,
  input  logic              resp0_grant,
  output logic [3:0]        outstanding,
  output logic [31:0]       r_count,
  output logic [31:0]       w_count,
  output logic              err_mismatch,
  output logic              err_unexpected
);
  localparam logic [3:0] MAX_OUT_4B = 4'(MAX_OUT);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q;
  logic              last_q;
  logic              mem_req_valid_q;
  logic              mem_req_isWrite_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [DATA_W-1:0] mem_req_data_q;
  logic [SIZE_W-1:0] mem_req_size_q;
  logic              resp0_valid_q;
  logic [DATA_W-1:0] resp0_data_q;
  logic [SIZE_W-1:0] resp0_size_q;
  logic [3:0]        outstanding_q, outstanding_d;
  logic [31:0]       r_count_q, w_count_q;
  logic              err_mismatch_q, err_unexpected_q;

  logic elig0, elig1, pick1, sel_any, sel_mismatch;
  logic resp_ready, resp_accept, resp_expected, issue_rd, retire_rd;

  always_comb begin
    elig0         = req0_valid && (outstanding_q < MAX_OUT_4B);
    elig1         = req1_valid;
    // On a tie the port that did not win last time takes the grant.
    pick1         = elig1 && (!elig0 || !last_q);
    sel_any       = (state_q == IDLE) && (elig0 || elig1);
    sel_mismatch  = pick1 ? !req1_isWrite : req0_isWrite;
    resp_ready    = !resp0_valid_q || resp0_grant;
    resp_accept   = mem_resp_valid && resp_ready;
    resp_expected = (outstanding_q != 4'd0);
    issue_rd      = (state_q == HOLD) && mem_req_grant && !mem_req_isWrite_q;
    retire_rd     = resp_accept && resp_expected;
    outstanding_d = outstanding_q;
    if (issue_rd && !retire_rd) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!issue_rd && retire_rd) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  // Grants are accept strobes for the current cycle; reset forces them low at once.
  assign req0_grant     = rst_n && sel_any && !pick1;
  assign req1_grant     = rst_n && sel_any && pick1;
  assign mem_resp_grant = rst_n && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      last_q            <= 1'b1;
      mem_req_valid_q   <= 1'b0;
      mem_req_isWrite_q <= 1'b0;
      mem_req_addr_q    <= '0;
      mem_req_data_q    <= '0;
      mem_req_size_q    <= '0;
      resp0_valid_q     <= 1'b0;
      resp0_data_q      <= '0;
      resp0_size_q      <= '0;
      outstanding_q     <= 4'd0;
      r_count_q         <= 32'd0;
      w_count_q         <= 32'd0;
      err_mismatch_q    <= 1'b0;
      err_unexpected_q  <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      case (state_q)
        IDLE: begin
          if (sel_any) begin
            last_q <= pick1;
            if (sel_mismatch) begin
              err_mismatch_q <= 1'b1;
            end else begin
              state_q           <= HOLD;
              mem_req_valid_q   <= 1'b1;
              mem_req_isWrite_q <= pick1;
              mem_req_addr_q    <= pick1 ? req1_addr : req0_addr;
              mem_req_data_q    <= pick1 ? req1_data : req0_data;
              mem_req_size_q    <= pick1 ? req1_size : req0_size;
            end
          end
        end
        HOLD: begin
          if (mem_req_grant) begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
            if (mem_req_isWrite_q) w_count_q <= w_count_q + 32'd1;
            else                   r_count_q <= r_count_q + 32'd1;
          end
        end
      endcase
      if (retire_rd) begin
        resp0_valid_q <= 1'b1;
        resp0_data_q  <= mem_resp_data;
        resp0_size_q  <= mem_resp_size;
      end else begin
        if (resp_accept) err_unexpected_q <= 1'b1;
        if (resp0_grant) resp0_valid_q <= 1'b0;
      end
    end
  end

  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_isWrite = mem_req_isWrite_q;
  assign mem_req_addr    = mem_req_addr_q;
  assign mem_req_data    = mem_req_data_q;
  assign mem_req_size    = mem_req_size_q;
  assign resp0_valid     = resp0_valid_q;
  assign resp0_data      = resp0_data_q;
  assign resp0_size      = resp0_size_q;
  assign outstanding     = outstanding_q;
  assign r_count         = r_count_q;
  assign w_count         = w_count_q;
  assign err_mismatch    = err_mismatch_q;
  assign err_unexpected  = err_unexpected_q;
endmodule
`default_nettype wire

// File: tb/tb_ami_mem_arbiter.sv
// tb_ami_mem_arbiter: randomized traffic against a transaction-level arbiter model,
// with scoreboard queues for memory requests and read responses.
`default_nettype none
module tb_ami_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = 64;
  localparam int MO = 4;
  localparam int PW = 1 + AW + DW + SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 0, req0_isWrite = 0, req0_grant;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic [SW-1:0] req0_size = '0;
  logic          req1_valid = 0, req1_isWrite = 0, req1_grant;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic [SW-1:0] req1_size = '0;
  logic          mem_req_valid, mem_req_isWrite, mem_req_grant = 0;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [SW-1:0] mem_req_size;
  logic          mem_resp_valid = 0, mem_resp_grant;
  logic [DW-1:0] mem_resp_data = '0;
  logic [SW-1:0] mem_resp_size = '0;
  logic          resp0_valid, resp0_grant = 0;
  logic [DW-1:0] resp0_data;
  logic [SW-1:0] resp0_size;
  logic [3:0]    outstanding;
  logic [31:0]   r_count, w_count;
  logic          err_mismatch, err_unexpected;

  always #5 clk = ~clk;

  ami_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_isWrite(req0_isWrite), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_size(req0_size), .req0_grant(req0_grant),
    .req1_valid(req1_valid), .req1_isWrite(req1_isWrite), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_size(req1_size), .req1_grant(req1_grant),
    .mem_req_valid(mem_req_valid), .mem_req_isWrite(mem_req_isWrite),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
    .mem_req_grant(mem_req_grant),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_size(mem_resp_size), .mem_resp_grant(mem_resp_grant),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_size(resp0_size),
    .resp0_grant(resp0_grant),
    .outstanding(outstanding), .r_count(r_count), .w_count(w_count),
    .err_mismatch(err_mismatch), .err_unexpected(err_unexpected)
  );

  int total = 0;
  int bad = 0;

  logic [PW-1:0]    exp_memq[$];
  logic [DW+SW-1:0] exp_respq[$];
  logic [DW+SW-1:0] mem_pend[$];

  int p_req0, p_req1, p_mis, p_mg, p_rg, p_resp;
  bit resp_en;

  // Transaction-level model: 0 free, 1 just granted, 2 request on the memory bus.
  int m_stage, m_out, m_rd, m_wr;
  bit m_last, m_emis, m_eunx, m_r0v, m_cur_w;
  bit acc0, acc1, racc;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [DW-1:0] rnd_bits();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit coin(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_out = 0; m_rd = 0; m_wr = 0;
    m_last = 1'b1; m_emis = 0; m_eunx = 0; m_r0v = 0; m_cur_w = 0;
    acc0 = 0; acc1 = 0; racc = 0;
    exp_memq.delete(); exp_respq.delete(); mem_pend.delete();
  endtask

  // Scoreboard monitor: pops whenever the DUT completes a handshake on an output channel.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_valid && mem_req_grant) begin
        if (exp_memq.size() == 0) fail_now("mem_req_without_grant");
        else chk("mem_req_fields", {mem_req_isWrite, mem_req_addr, mem_req_data, mem_req_size},
                 exp_memq.pop_front());
      end
      if (resp0_valid && resp0_grant) begin
        if (exp_respq.size() == 0) fail_now("resp0_without_mem_resp");
        else chk("resp0_fields", {resp0_data, resp0_size}, exp_respq.pop_front());
      end
    end
  end

  task automatic cycle();
    bit e0, e1, g0, g1, p1, acc_resp, load;
    @(negedge clk);
    acc0 = req0_grant; acc1 = req1_grant; racc = 0;
    if (m_stage == 1) m_stage = 2;
    chk("outstanding", outstanding, m_out);
    chk("mem_req_valid", mem_req_valid, m_stage == 2);
    chk("resp0_valid", resp0_valid, m_r0v);
    chk("mem_resp_grant", mem_resp_grant, !m_r0v || resp0_grant);
    e0 = req0_valid && (m_out < MO);
    e1 = req1_valid;
    g0 = 0; g1 = 0;
    if (m_stage == 0 && (e0 || e1)) begin
      p1 = (e0 && e1) ? !m_last : e1;
      g1 = p1; g0 = !p1;
    end
    chk("req0_grant", req0_grant, g0);
    chk("req1_grant", req1_grant, g1);
    acc_resp = mem_resp_valid && (!m_r0v || resp0_grant);
    load = 0;
    if (acc_resp) begin
      racc = 1;
      if (m_out > 0) begin
        load = 1;
        m_out--;
        if (mem_pend.size() > 0) exp_respq.push_back(mem_pend[0]);
      end else begin
        m_eunx = 1;
      end
      if (mem_pend.size() > 0) void'(mem_pend.pop_front());
    end
    if (load) m_r0v = 1;
    else if (resp0_grant) m_r0v = 0;
    if (m_stage == 2 && mem_req_grant) begin
      m_stage = 0;
      if (m_cur_w) m_wr++;
      else begin
        m_rd++;
        m_out++;
        mem_pend.push_back({rnd_bits(), $urandom, $urandom});
      end
    end
    if (g0 || g1) begin
      m_last = g1;
      if (g1 ? !req1_isWrite : req0_isWrite) m_emis = 1;
      else begin
        m_stage = 1;
        m_cur_w = g1;
        exp_memq.push_back(g1 ? {1'b1, req1_addr, req1_data, req1_size}
                              : {1'b0, req0_addr, req0_data, req0_size});
      end
    end
    @(posedge clk);
    #1;
    if (acc0 || !req0_valid) begin
      req0_valid = coin(p_req0);
      req0_isWrite = coin(p_mis);
      req0_addr = {$urandom, $urandom};
      req0_data = rnd_bits();
      req0_size = {$urandom, $urandom};
    end
    if (acc1 || !req1_valid) begin
      req1_valid = coin(p_req1);
      req1_isWrite = !coin(p_mis);
      req1_addr = {$urandom, $urandom};
      req1_data = rnd_bits();
      req1_size = {$urandom, $urandom};
    end
    if (racc || !mem_resp_valid) begin
      mem_resp_valid = resp_en && (mem_pend.size() > 0) && coin(p_resp);
      if (mem_resp_valid) {mem_resp_data, mem_resp_size} = mem_pend[0];
    end
    mem_req_grant = coin(p_mg);
    resp0_grant = coin(p_rg);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_knobs(input int r0, input int r1, input int mis, input int mg,
                           input int rg, input int rp, input bit en);
    p_req0 = r0; p_req1 = r1; p_mis = mis; p_mg = mg; p_rg = rg; p_resp = rp; resp_en = en;
  endtask

  task automatic drain_and_check(input string tag);
    set_knobs(0, 0, 0, 100, 100, 100, 1);
    run(60);
    chk({tag, "_memq_empty"}, exp_memq.size(), 0);
    chk({tag, "_respq_empty"}, exp_respq.size(), 0);
    chk({tag, "_r_count"}, r_count, m_rd);
    chk({tag, "_w_count"}, w_count, m_wr);
    chk({tag, "_outstanding"}, outstanding, m_out);
    chk({tag, "_err_mismatch"}, err_mismatch, m_emis);
    chk({tag, "_err_unexpected"}, err_unexpected, m_eunx);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req0_grant"}, req0_grant, 0);
    chk({tag, "_req1_grant"}, req1_grant, 0);
    chk({tag, "_mem_resp_grant"}, mem_resp_grant, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_resp0_valid"}, resp0_valid, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_counts"}, {r_count, w_count}, 0);
    chk({tag, "_errors"}, {err_mismatch, err_unexpected}, 0);
  endtask

  initial begin
    int waited;
    model_reset();
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    req0_valid = 1; req1_valid = 1; req1_isWrite = 1; mem_resp_valid = 1;
    #12;
    check_reset_outputs("reset");
    req0_valid = 0; req1_valid = 0; req1_isWrite = 0; mem_resp_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;

    set_knobs(60, 60, 0, 70, 70, 60, 1);
    run(400);

    // Read-only traffic with the response path shut hits the outstanding cap.
    set_knobs(100, 0, 0, 100, 100, 100, 0);
    run(40);
    chk("cap_outstanding", outstanding, MO);
    resp_en = 1;
    run(40);

    set_knobs(100, 100, 0, 100, 100, 100, 1);
    run(100);

    set_knobs(100, 30, 0, 100, 0, 100, 1);
    run(60);
    p_rg = 50;
    run(60);

    set_knobs(70, 70, 25, 60, 60, 60, 1);
    run(200);
    drain_and_check("drain1");

    // A response with nothing in flight must be dropped.
    mem_pend.push_back({rnd_bits(), $urandom, $urandom});
    run(10);
    chk("unexpected_flag", err_unexpected, 1);
    chk("unexpected_outstanding", outstanding, 0);

    // Reset while a request sits on the memory bus unaccepted.
    set_knobs(0, 100, 0, 0, 100, 100, 1);
    waited = 0;
    while (!mem_req_valid && waited < 20) begin
      cycle();
      waited++;
    end
    if (!mem_req_valid) fail_now("hold_timeout");
    #2 rst_n = 0;
    req0_valid = 1; req0_isWrite = 0;
    req1_valid = 1; req1_isWrite = 1;
    mem_resp_valid = 0; mem_req_grant = 0;
    #1;
    check_reset_outputs("midhold_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    set_knobs(100, 100, 0, 100, 100, 100, 1);
    cycle();
    chk("post_reset_first_port0", acc0, 1);
    run(80);
    drain_and_check("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
